// File: rtl/pulse_train_decoder.sv
// Decodes a pulse train into pulses-per-set, set count and a consistency flag.
// Result latches on LEDR with a one-cycle DONE strobe when the line stays low long enough.
module pulse_train_decoder #(
   parameter int unsigned MIN_HIGH_CYCLES = 1_000_000,
   parameter int unsigned SET_GAP_CYCLES  = 25_000_000,
   parameter int unsigned END_GAP_CYCLES  = 43_750_000
) (
   input  logic       CLOCK_50,
   input  logic       KEY,
   input  logic       PULSE_IN,
   output logic [9:0] LEDR,
   output logic       DONE
);

   localparam logic [31:0] MIN_C = 32'(MIN_HIGH_CYCLES);
   localparam logic [31:0] SET_C = 32'(SET_GAP_CYCLES);
   localparam logic [31:0] END_C = 32'(END_GAP_CYCLES);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q, prev_q;
   logic [31:0] run_q, run_d;
   logic [3:0]  pulse_cnt_q, pulse_cnt_d;
   logic [3:0]  set_cnt_q, set_cnt_d;
   logic [3:0]  ref_cnt_q, ref_cnt_d;
   logic        err_q, err_d;
   logic [9:0]  ledr_q, ledr_d;
   logic        done_q, done_d;

   logic        rise, fall;
   logic [3:0]  cs_set, cs_ref;
   logic        cs_err;

   always_comb begin
      rise = sync2_q & ~prev_q;
      fall = ~sync2_q & prev_q;

      // Counters as they would stand after closing the current set; empty sets are ignored.
      cs_set = set_cnt_q;
      cs_ref = ref_cnt_q;
      cs_err = err_q;
      if (pulse_cnt_q != 4'd0) begin
         if (set_cnt_q == 4'd15) cs_err = 1'b1;
         else                    cs_set = set_cnt_q + 4'd1;
         if (set_cnt_q == 4'd0)            cs_ref = pulse_cnt_q;
         else if (pulse_cnt_q != ref_cnt_q) cs_err = 1'b1;
      end

      state_d     = state_q;
      run_d       = run_q;
      pulse_cnt_d = pulse_cnt_q;
      set_cnt_d   = set_cnt_q;
      ref_cnt_d   = ref_cnt_q;
      err_d       = err_q;
      ledr_d      = ledr_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d     = HIGH;
               run_d       = 32'd0;
               pulse_cnt_d = 4'd0;
               set_cnt_d   = 4'd0;
               ref_cnt_d   = 4'd0;
               err_d       = 1'b0;
            end
         end
         HIGH: begin
            if (fall) begin
               state_d = LOW;
               run_d   = 32'd0;
               if (run_q >= MIN_C) begin
                  if (pulse_cnt_q == 4'd15) err_d = 1'b1;
                  else                      pulse_cnt_d = pulse_cnt_q + 4'd1;
               end
            end else if (run_q < MIN_C) begin
               run_d = run_q + 32'd1;
            end
         end
         LOW: begin
            if (run_q + 32'd1 >= END_C) begin
               // End of train beats a coincident rising edge, which then opens the next train.
               ledr_d      = {1'b1, cs_err, cs_set, cs_ref};
               done_d      = 1'b1;
               state_d     = rise ? HIGH : IDLE;
               run_d       = 32'd0;
               pulse_cnt_d = 4'd0;
               set_cnt_d   = 4'd0;
               ref_cnt_d   = 4'd0;
               err_d       = 1'b0;
            end else if (rise) begin
               state_d = HIGH;
               run_d   = 32'd0;
               if (run_q >= SET_C) begin
                  pulse_cnt_d = 4'd0;
                  set_cnt_d   = cs_set;
                  ref_cnt_d   = cs_ref;
                  err_d       = cs_err;
               end
            end else begin
               run_d = run_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         run_q       <= 32'd0;
         pulse_cnt_q <= 4'd0;
         set_cnt_q   <= 4'd0;
         ref_cnt_q   <= 4'd0;
         err_q       <= 1'b0;
         ledr_q      <= 10'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= PULSE_IN;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         run_q       <= run_d;
         pulse_cnt_q <= pulse_cnt_d;
         set_cnt_q   <= set_cnt_d;
         ref_cnt_q   <= ref_cnt_d;
         err_q       <= err_d;
         ledr_q      <= ledr_d;
         done_q      <= done_d;
      end
   end

   assign LEDR = ledr_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_pulse_train_decoder.sv
// Bench for pulse_train_decoder: directed trains plus randomized trains against a run-length model.
module tb_pulse_train_decoder;

   localparam int MIN_H = 4;
   localparam int SET_G = 20;
   localparam int END_G = 35;

   logic       clk = 1'b0;
   logic       key;
   logic       pin;
   logic [9:0] ledr;
   logic       done;

   int vectors     = 0;
   int miscompares = 0;

   logic [9:0] got_q[$];

   always #5 clk = ~clk;

   pulse_train_decoder #(
      .MIN_HIGH_CYCLES(MIN_H),
      .SET_GAP_CYCLES (SET_G),
      .END_GAP_CYCLES (END_G)
   ) dut (
      .CLOCK_50(clk),
      .KEY     (key),
      .PULSE_IN(pin),
      .LEDR    (ledr),
      .DONE    (done)
   );

   // Every DONE cycle records the result shown on LEDR at that moment.
   always @(negedge clk) if (done) got_q.push_back(ledr);

   // Reference: walk the (high, low) run lengths and apply the decoding rules directly.
   task automatic model(input int segs[$], output logic [9:0] exp_q[$]);
      int   p, s, r;
      logic e;
      bit   first;
      p = 0; s = 0; r = 0; e = 1'b0;
      exp_q = {};
      for (int i = 0; i + 1 < segs.size(); i += 2) begin
         if (segs[i] >= MIN_H) begin
            if (p == 15) e = 1'b1;
            else         p++;
         end
         if (segs[i+1] >= SET_G) begin
            if (p > 0) begin
               first = (s == 0);
               if (s == 15) e = 1'b1;
               else         s++;
               if (first)       r = p;
               else if (p != r) e = 1'b1;
               p = 0;
            end
            if (segs[i+1] >= END_G) begin
               exp_q.push_back({1'b1, e, 4'(s), 4'(r)});
               p = 0; s = 0; r = 0; e = 1'b0;
            end
         end
      end
   endtask

   task automatic drive(input int segs[$]);
      for (int i = 0; i < segs.size(); i++) begin
         pin = (i % 2 == 0);
         repeat (segs[i]) @(negedge clk);
      end
      pin = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic add_set(inout int q[$], input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         q.push_back(10);
         q.push_back((k == n - 1) ? gap : 10);
      end
   endtask

   task automatic test_reset;
      key = 1'b0;
      pin = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (ledr !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_ledr got %b want %b", ledr, 10'd0);
      end
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_done got %b want 0", done);
      end
      key = 1'b1;
      repeat (40) @(negedge clk);
      vectors++;
      if (got_q.size() != 0 || ledr !== 10'd0) begin
         miscompares++;
         $display("FAIL idle_quiet got dones=%0d ledr=%b want dones=0 ledr=0", got_q.size(), ledr);
      end
   endtask

   task automatic test_nominal;
      int segs[$];
      segs = {};
      add_set(segs, 4, 30);
      add_set(segs, 4, 30);
      add_set(segs, 4, 50);
      got_q = {};
      drive(segs);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b10_0011_0100) begin
         miscompares++;
         $display("FAIL nominal_3x4 got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b10_0011_0100);
      end
   endtask

   task automatic test_mismatch;
      int segs[$];
      segs = {};
      add_set(segs, 4, 30);
      add_set(segs, 3, 50);
      got_q = {};
      drive(segs);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b11_0010_0100) begin
         miscompares++;
         $display("FAIL mismatch_4_3 got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b11_0010_0100);
      end
   endtask

   task automatic test_glitch;
      int segs[$];
      // Glitches inside the set, then a glitch-only set that must not count.
      segs = {2, 10, 10, 10, 1, 10, 10, 30, 2, 50};
      got_q = {};
      drive(segs);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b10_0001_0010) begin
         miscompares++;
         $display("FAIL glitch_filter got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b10_0001_0010);
      end
   endtask

   task automatic test_reset_mid_train;
      int segs[$];
      segs = {};
      add_set(segs, 4, 30);
      segs.push_back(10); segs.push_back(10);
      segs.push_back(10); segs.push_back(10);
      got_q = {};
      for (int i = 0; i < segs.size(); i++) begin
         pin = (i % 2 == 0);
         repeat (segs[i]) @(negedge clk);
      end
      key = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (ledr !== 10'd0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_clear got ledr=%b done=%b want ledr=0 done=0", ledr, done);
      end
      key = 1'b1;
      repeat (60) @(negedge clk);
      vectors++;
      if (got_q.size() != 0 || ledr !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_mid_nodone got dones=%0d ledr=%b want dones=0 ledr=0", got_q.size(), ledr);
      end
      drive('{10, 50});
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b10_0001_0001) begin
         miscompares++;
         $display("FAIL reset_mid_next got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b10_0001_0001);
      end
   endtask

   task automatic test_reset_line_high;
      got_q = {};
      key = 1'b0;
      pin = 1'b1;
      repeat (3) @(negedge clk);
      key = 1'b1;
      drive('{10, 10, 10, 50});
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b10_0001_0010) begin
         miscompares++;
         $display("FAIL reset_line_high got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b10_0001_0010);
      end
   endtask

   task automatic test_back_to_back;
      got_q = {};
      drive('{10, 10, 10, END_G, 10, 10, 10, 10, 10, 50});
      vectors++;
      if (got_q.size() != 2) begin
         miscompares++;
         $display("FAIL b2b_count got %0d want 2", got_q.size());
      end else begin
         vectors++;
         if (got_q[0] !== 10'b10_0001_0010) begin
            miscompares++;
            $display("FAIL b2b_first got %b want %b", got_q[0], 10'b10_0001_0010);
         end
         vectors++;
         if (got_q[1] !== 10'b10_0001_0011) begin
            miscompares++;
            $display("FAIL b2b_second got %b want %b", got_q[1], 10'b10_0001_0011);
         end
      end
      got_q = {};
      drive('{10, END_G - 1, 10, 50});
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b10_0010_0001) begin
         miscompares++;
         $display("FAIL gap_below_end got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b10_0010_0001);
      end
   endtask

   task automatic test_saturate;
      int segs[$];
      segs = {};
      for (int k = 0; k < 17; k++) add_set(segs, 1, 30);
      add_set(segs, 1, 50);
      got_q = {};
      drive(segs);
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b11_1111_0001) begin
         miscompares++;
         $display("FAIL set_saturate got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b11_1111_0001);
      end
   endtask

   task automatic test_stuck_high;
      logic [9:0] held;
      held = ledr;
      got_q = {};
      pin = 1'b1;
      repeat (300) @(negedge clk);
      vectors++;
      if (got_q.size() != 0 || ledr !== 10'b11_1111_0001 || ledr !== held) begin
         miscompares++;
         $display("FAIL stuck_high_hold got dones=%0d ledr=%b want dones=0 ledr=%b",
                  got_q.size(), ledr, 10'b11_1111_0001);
      end
      drive('{1, 50});
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== 10'b10_0001_0001) begin
         miscompares++;
         $display("FAIL stuck_high_release got dones=%0d ledr=%b want dones=1 ledr=%b",
                  got_q.size(), ledr, 10'b10_0001_0001);
      end
   endtask

   task automatic test_random;
      int         segs[$];
      logic [9:0] exp_q[$];
      int         nsets, base, n;
      for (int t = 0; t < 8; t++) begin
         segs  = {};
         nsets = $urandom_range(4, 1);
         base  = $urandom_range(6, 1);
         for (int s = 0; s < nsets; s++) begin
            n = ($urandom_range(2, 0) == 0) ? $urandom_range(6, 1) : base;
            for (int k = 0; k < n; k++) begin
               if ($urandom_range(3, 0) == 0) begin
                  segs.push_back($urandom_range(2, 1));
                  segs.push_back($urandom_range(15, 5));
               end
               segs.push_back($urandom_range(14, 6));
               if (k < n - 1)          segs.push_back($urandom_range(15, 5));
               else if (s < nsets - 1) segs.push_back($urandom_range(31, 24));
               else                    segs.push_back($urandom_range(60, 40));
            end
         end
         model(segs, exp_q);
         got_q = {};
         drive(segs);
         vectors++;
         if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count train %0d got %0d want %0d", t, got_q.size(), exp_q.size());
         end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
               vectors++;
               if (got_q[j] !== exp_q[j]) begin
                  miscompares++;
                  $display("FAIL random_result train %0d got %b want %b", t, got_q[j], exp_q[j]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_mismatch;
      test_glitch;
      test_reset_mid_train;
      test_reset_line_high;
      test_back_to_back;
      test_saturate;
      test_stuck_high;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pulse_train_decoder.md
PULSE_TRAIN_DECODER -- requirements
Module: pulse_train_decoder

Interface
REQ-001 SHALL have parameter MIN_HIGH_CYCLES, default 1_000_000: shortest high run counted as a pulse; shorter runs are glitches.
REQ-002 SHALL have parameter SET_GAP_CYCLES, default 25_000_000: low run at or above this length closes a set (2 ticks of 12_500_000).
REQ-003 SHALL have parameter END_GAP_CYCLES, default 43_750_000: low run reaching this length ends the train (3.5 ticks).
REQ-004 SHALL have port CLOCK_50, input, 1 bit: single clock, all flops on rising edge.
REQ-005 SHALL have port KEY, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port PULSE_IN, input, 1 bit: asynchronous pulse-train line (high = pulse).
REQ-007 SHALL have port LEDR, output, 10 bits: [3:0] pulses per set, [7:4] set count, [8] err, [9] valid.
REQ-008 SHALL have port DONE, output, 1 bit: single-cycle strobe when a train result is latched.

Function
REQ-009 SHALL pass PULSE_IN through a 2-flop synchronizer; all edges are detected on the synchronized signal; state acts 1 cycle after a synchronized edge (3 cycles pin-to-state).
REQ-010 SHALL implement states IDLE, HIGH, LOW; 32-bit run counter; 4-bit pulse_cnt, set_cnt, ref_cnt; sticky err_run.
REQ-011 IDLE: on rising edge -> HIGH, clear pulse_cnt, set_cnt, ref_cnt, err_run, run counter; otherwise stay.
REQ-012 HIGH: run counter increments, saturating at MIN_HIGH_CYCLES; on falling edge -> LOW, clear run counter; increment pulse_cnt only if run counter >= MIN_HIGH_CYCLES.
REQ-013 LOW: run counter increments, saturating at END_GAP_CYCLES.
REQ-014 LOW, rising edge with run counter < SET_GAP_CYCLES: intra-set gap -> HIGH, counts unchanged.
REQ-015 LOW, rising edge with SET_GAP_CYCLES <= run counter < END_GAP_CYCLES: close set -> HIGH.
REQ-016 Close set: set_cnt+1; if first set, ref_cnt <= pulse_cnt; else set err_run when pulse_cnt != ref_cnt; pulse_cnt <= 0.
REQ-017 LOW, run counter reaching END_GAP_CYCLES: close set per REQ-016, then latch results (LEDR[3:0]=ref, or pulse_cnt if first set; LEDR[7:4]=final set count; LEDR[8]=final err), LEDR[9]=1, DONE=1 for one cycle, -> IDLE.
REQ-018 Rising edge in same cycle END_GAP_CYCLES is reached: end-of-train wins; then the edge starts a new train (-> HIGH, counters cleared per REQ-011).
REQ-019 Set with zero counted pulses (glitches only) SHALL NOT increment set_cnt.
REQ-020 pulse_cnt and set_cnt SHALL saturate at 15; saturation sets err_run.
REQ-021 Latched LEDR SHALL hold until the next REQ-017 latch or reset; a new train in progress does not alter LEDR.
REQ-022 Line stuck high: HIGH persists indefinitely, no output change.

Reset
REQ-023 KEY low SHALL immediately force IDLE, synchronizer flops 0, all counters 0, LEDR=0, DONE=0, regardless of state or mid-train.
REQ-024 After KEY rises, a line already high SHALL be treated as a rising edge only after it is seen low then high (synchronizer resets to 0, so an initially high line counts as an edge: defined behaviour is -> HIGH).

Verification (bench params MIN_HIGH_CYCLES=4, SET_GAP_CYCLES=20, END_GAP_CYCLES=35, tick=10 cycles)
REQ-025 3 sets of 4 pulses (10 high/10 low, 30-low set gap, 50-low end) -> DONE once, LEDR=10'b10_0011_0100.
REQ-026 Sets of 4,3 pulses -> LEDR[3:0]=4, LEDR[7:4]=2, LEDR[8]=1, LEDR[9]=1.
REQ-027 2-cycle glitches interleaved in a 1-set 2-pulse train -> LEDR[3:0]=2, LEDR[7:4]=1, err=0.
REQ-028 KEY pulsed low mid-second-set -> LEDR=0, DONE never asserts; next full 1x1 train -> LEDR[3:0]=1, LEDR[7:4]=1.
REQ-029 Rising edge on exact cycle run counter hits 35 -> DONE for first train, second train decoded independently with correct counts.
REQ-030 18 sets of 1 pulse -> LEDR[7:4]=15, LEDR[8]=1.
